// File: rtl/dff_pipe_reg_if.sv
// Bus bundle for dff_pipe_reg: shift control and input word in, final stage and occupancy out.
// The master modport is the producer/consumer side; the slave modport is the pipeline itself.
interface dff_pipe_reg_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int FW = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic             parity_inj;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [FW-1:0]    fill;
  logic             full;
  logic             empty;
  logic             parity_err;

  modport master (
    output en, flush, d, d_valid, parity_inj,
    input  q, q_valid, fill, full, empty, parity_err
  );

  modport slave (
    input  en, flush, d, d_valid, parity_inj,
    output q, q_valid, fill, full, empty, parity_err
  );
endinterface

// File: rtl/dff_pipe_reg.sv
// WIDTH x DEPTH register pipeline with per-stage valids, flush, registered fill and full/empty.
// Optional macro PIPE_PARITY_EN adds a per-stage even-parity bit and a parity_err output.
module dff_pipe_reg #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic           clk,
  input logic           reset,
  dff_pipe_reg_if.slave bus
);
  localparam int FW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_reg [DEPTH];
  logic [WIDTH-1:0] shift_data [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] shift_valid;
  logic [FW-1:0]    fill_reg;
  logic [FW-1:0]    fill_next;

  // Value each stage would take on a shift: stage 0 from the bus, others from their predecessor.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign shift_data[gi]  = bus.d;
        assign shift_valid[gi] = bus.d_valid;
      end else begin : g_body
        assign shift_data[gi]  = data_reg[gi-1];
        assign shift_valid[gi] = valid_reg[gi-1];
      end
    end
  endgenerate

  // Occupancy tracks the valid popcount: one in at stage 0, one out at the final stage.
  always_comb begin
    fill_next = fill_reg + FW'(bus.d_valid) - FW'(valid_reg[DEPTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!reset || bus.flush) begin
      for (int i = 0; i < DEPTH; i++) data_reg[i] <= RESET_VAL;
      valid_reg <= '0;
      fill_reg  <= '0;
    end else if (bus.en) begin
      for (int i = 0; i < DEPTH; i++) data_reg[i] <= shift_data[i];
      valid_reg <= shift_valid;
      fill_reg  <= fill_next;
    end
  end

  assign bus.q       = data_reg[DEPTH-1];
  assign bus.q_valid = valid_reg[DEPTH-1];
  assign bus.fill    = fill_reg;
  assign bus.full    = (fill_reg == FW'(DEPTH));
  assign bus.empty   = (fill_reg == '0);

`ifdef PIPE_PARITY_EN
  localparam logic RESET_PAR = ^RESET_VAL;

  logic [DEPTH-1:0] par_reg;
  logic [DEPTH-1:0] shift_par;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_par
      if (gi == 0) begin : g_head
        assign shift_par[gi] = (^bus.d) ^ bus.parity_inj;
      end else begin : g_body
        assign shift_par[gi] = par_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset || bus.flush) begin
      par_reg <= {DEPTH{RESET_PAR}};
    end else if (bus.en) begin
      par_reg <= shift_par;
    end
  end

  // Derived only from final-stage registers, so it moves on the same edge as q.
  assign bus.parity_err = valid_reg[DEPTH-1] &
                          ((^data_reg[DEPTH-1]) != par_reg[DEPTH-1]);
`else
  logic unused_parity_inj;
  assign unused_parity_inj = bus.parity_inj;
  assign bus.parity_err    = 1'b0;
`endif
endmodule

// File: tb/tb_dff_pipe_reg.sv
// Directed self-checking bench for dff_pipe_reg at WIDTH=8, DEPTH=4, RESET_VAL=0.
// Parity scenario expectations follow whether PIPE_PARITY_EN is defined for the build.
module tb_dff_pipe_reg;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  dff_pipe_reg_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  dff_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic en, input logic flush, input logic [7:0] d,
                       input logic dv, input logic inj);
    bus.en         = en;
    bus.flush      = flush;
    bus.d          = d;
    bus.d_valid    = dv;
    bus.parity_inj = inj;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t rst=%b en=%b fl=%b d=%h dv=%b inj=%b | q=%h qv=%b fill=%0d full=%b empty=%b perr=%b",
             $time, reset, bus.en, bus.flush, bus.d, bus.d_valid, bus.parity_inj,
             bus.q, bus.q_valid, bus.fill, bus.full, bus.empty, bus.parity_err);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    tick();
    tick();
    n_cmp++; if (bus.q !== 8'h00) begin n_err++; $display("FAIL reset_q got=%h exp=00", bus.q); end
    n_cmp++; if (bus.q_valid !== 1'b0) begin n_err++; $display("FAIL reset_qv got=%b exp=0", bus.q_valid); end
    n_cmp++; if (bus.fill !== 3'd0) begin n_err++; $display("FAIL reset_fill got=%0d exp=0", bus.fill); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    n_cmp++; if (bus.parity_err !== 1'b0) begin n_err++; $display("FAIL reset_perr got=%b exp=0", bus.parity_err); end
    reset = 1'b1;
  endtask

  task automatic test_latency();
    int         exp_fill [5] = '{1, 1, 1, 1, 0};
    logic       exp_qv   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] exp_q    [5] = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'h00};
    for (int k = 0; k < 5; k++) begin
      if (k == 0) drive(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0);
      else        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      n_cmp++; if (bus.fill !== 3'(exp_fill[k])) begin n_err++; $display("FAIL lat_fill edge=%0d got=%0d exp=%0d", k+1, bus.fill, exp_fill[k]); end
      n_cmp++; if (bus.q_valid !== exp_qv[k]) begin n_err++; $display("FAIL lat_qv edge=%0d got=%b exp=%b", k+1, bus.q_valid, exp_qv[k]); end
      n_cmp++; if (bus.q !== exp_q[k]) begin n_err++; $display("FAIL lat_q edge=%0d got=%h exp=%h", k+1, bus.q, exp_q[k]); end
    end
  endtask

  task automatic test_fill();
    int exp_fill;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 1'b0, 8'(k), 1'b1, 1'b0);
      tick();
      exp_fill = (k < DEPTH) ? k : DEPTH;
      n_cmp++; if (bus.fill !== 3'(exp_fill)) begin n_err++; $display("FAIL fill_count edge=%0d got=%0d exp=%0d", k, bus.fill, exp_fill); end
      n_cmp++; if (bus.full !== (k >= DEPTH)) begin n_err++; $display("FAIL fill_full edge=%0d got=%b exp=%b", k, bus.full, (k >= DEPTH)); end
      n_cmp++; if (bus.empty !== 1'b0) begin n_err++; $display("FAIL fill_empty edge=%0d got=%b exp=0", k, bus.empty); end
      if (k >= DEPTH) begin
        n_cmp++; if (bus.q !== 8'(k - 3) || bus.q_valid !== 1'b1) begin n_err++; $display("FAIL fill_q edge=%0d got=%h/%b exp=%h/1", k, bus.q, bus.q_valid, 8'(k - 3)); end
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp_q [4] = '{8'h02, 8'h03, 8'h04, 8'h00};
    drive(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b0, 8'(k), 1'b1, 1'b0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 8'h55, 1'b1, 1'b0);
      tick();
      n_cmp++; if (bus.q !== 8'h01 || bus.q_valid !== 1'b1 || bus.fill !== 3'd4) begin
        n_err++; $display("FAIL stall_hold cyc=%0d got=%h/%b/%0d exp=01/1/4", k, bus.q, bus.q_valid, bus.fill);
      end
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      n_cmp++; if (bus.q !== exp_q[k] || bus.q_valid !== (k < 3)) begin
        n_err++; $display("FAIL stall_resume edge=%0d got=%h/%b exp=%h/%b", k+1, bus.q, bus.q_valid, exp_q[k], (k < 3));
      end
      n_cmp++; if (bus.fill !== 3'(3 - k)) begin n_err++; $display("FAIL stall_fill edge=%0d got=%0d exp=%0d", k+1, bus.fill, 3 - k); end
    end
  endtask

  task automatic test_flush_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b0, 8'(8'h10 + k), 1'b1, 1'b0);
      tick();
    end
    n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL flush_prefull got=%b exp=1", bus.full); end
    drive(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
    tick();
    n_cmp++; if (bus.fill !== 3'd0 || bus.q_valid !== 1'b0 || bus.q !== 8'h00 || bus.empty !== 1'b1) begin
      n_err++; $display("FAIL flush_clear got=fill%0d/qv%b/q%h/e%b exp=fill0/qv0/q00/e1", bus.fill, bus.q_valid, bus.q, bus.empty);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 8'(8'h20 + k), 1'b1, 1'b0);
      tick();
    end
    n_cmp++; if (bus.fill !== 3'd2) begin n_err++; $display("FAIL refill_fill got=%0d exp=2", bus.fill); end
    reset = 1'b0;
    drive(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
    tick();
    n_cmp++; if (bus.fill !== 3'd0 || bus.empty !== 1'b1 || bus.q_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset got=fill%0d/e%b/qv%b exp=fill0/e1/qv0", bus.fill, bus.empty, bus.q_valid);
    end
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    n_cmp++; if (bus.fill !== 3'd0) begin n_err++; $display("FAIL postreset_hold got=%0d exp=0", bus.fill); end
  endtask

  task automatic test_parity();
    logic exp_perr [5];
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 5; k++) begin
`ifdef PIPE_PARITY_EN
        exp_perr[k] = (pass == 0) && (k == 3);
`else
        exp_perr[k] = 1'b0;
`endif
        if (k == 0) drive(1'b1, 1'b0, 8'h03, 1'b1, (pass == 0));
        else        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        n_cmp++; if (bus.parity_err !== exp_perr[k]) begin
          n_err++; $display("FAIL parity pass=%0d edge=%0d got=%b exp=%b", pass, k+1, bus.parity_err, exp_perr[k]);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    test_reset();
    test_latency();
    test_fill();
    test_stall();
    test_flush_reset();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dff_pipe_reg.md
Name: dff_pipe_reg

Overview:
Parametrised successor to the single D flip-flop. It is a WIDTH-bit, DEPTH-stage register pipeline with per-stage valid tracking, a shift enable, a synchronous flush, and a registered occupancy count with full/empty flags. It serves as the standard delay/retiming element between datapath blocks.

Parameters:
WIDTH, 8, data bits per stage (>=1)
DEPTH, 4, number of register stages (>=1)
RESET_VAL, 0, value loaded into every stage's data on reset and on flush (WIDTH bits)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
en  input  1  shift enable; 1 advances the pipeline one stage
flush  input  1  synchronous clear of all stages and valids
d  input  WIDTH  input data into stage 0
d_valid  input  1  valid qualifier for d
parity_inj  input  1  parity error injection (used only with PIPE_PARITY_EN; ignored otherwise)
q  output  WIDTH  data of final stage (stage DEPTH-1), registered
q_valid  output  1  valid bit of final stage
fill  output  $clog2(DEPTH+1)  number of stages currently holding valid data
full  output  1  fill == DEPTH
empty  output  1  fill == 0
parity_err  output  1  parity mismatch on final stage (tied 0 without PIPE_PARITY_EN)

Behaviour:
- All state changes on rising clk only; no combinational path from inputs to outputs.
- Priority per edge: reset (low) > flush > en > hold.
- Reset (reset==0 at edge):
  - every stage data = RESET_VAL, every valid = 0, fill = 0.
  - Outputs after the edge: q=RESET_VAL, q_valid=0, fill=0, full=0, empty=1, parity_err=0.
  - Reset mid-stream discards all contents. Reset has no effect between edges.
- Flush (reset==1, flush==1): same state result as reset, regardless of en.
- Shift (reset==1, flush==0, en==1):
  - stage0 <= {d, d_valid}; stage i <= stage i-1 for i=1..DEPTH-1.
  - The old final stage is dropped. There is no backpressure; data leaves unconditionally.
  - d is captured even when d_valid==0; d_valid only qualifies it.
- Hold (en==0): all stages, valids and fill unchanged.
- Latency: a word presented with en=1 at edge N appears on q after edge N+DEPTH-1, provided en=1 on every intervening edge. Latency is counted in enabled edges, not cycles. With DEPTH=1, q follows d one enabled edge later.
- fill is a registered counter, updated on shift as fill + d_valid - valid[DEPTH-1]. It always equals the popcount of the stage valids.
  - Full pipeline with d_valid=1 and outgoing valid=1: fill stays at DEPTH (no overflow).
  - Empty pipeline with d_valid=0: fill stays at 0 (no underflow).
- full and empty are decoded from the registered fill, so they are glitch-free and change on the same edge as fill.
- Bubbles (d_valid=0) propagate as invalid stages. q_valid=0 marks them; q still shows the bubble's captured data.

Optional Feature:
Macro PIPE_PARITY_EN.
- Defined:
  - Each stage carries an extra parity bit, computed at stage 0 as even parity of d.
  - When parity_inj=1 on a shift edge, the stored parity for that word is inverted.
  - parity_err = q_valid AND (XOR of q != stored parity of final stage), registered with the final stage.
  - Reset and flush clear all parity bits to parity(RESET_VAL).
- Not defined: no parity storage, parity_inj is ignored, parity_err is constant 0.

Test Plan:
- Reset: hold reset=0 for 2 edges with en=1, d=8'hFF, d_valid=1 -> q=8'h00, q_valid=0, fill=0, empty=1, full=0.
- Latency: after reset (WIDTH=8, DEPTH=4, en=1), drive d=8'hA5 with d_valid=1 for one edge, then d_valid=0 -> q=8'hA5 and q_valid=1 exactly after the 4th edge; fill goes 1,1,1,1,0.
- Fill/full: stream d_valid=1, d=1,2,3,4,5... -> fill 1,2,3,4; full=1 after edge 4; fill holds at 4 while streaming; q shows 1,2,3... from edge 4 onward.
- Stall: with pipeline full (d=1..4), set en=0 for 3 edges with d=8'h55 -> q, q_valid and fill frozen; on resume q advances by exactly one stage per enabled edge; 8'h55 is never captured.
- Flush vs en, then reset mid-stream: flush=1 and en=1 on the same edge with full pipeline -> fill=0, q_valid=0, q=RESET_VAL. Then refill 2 words, pull reset=0 -> fill=0 on that edge.
- Parity (PIPE_PARITY_EN defined): shift in 8'h03 with parity_inj=1 -> parity_err=1 only in the cycle q=8'h03 and q_valid=1. With parity_inj=0 -> parity_err stays 0. Same build without the macro -> parity_err always 0.
